// File: rtl/tl_cpl_rx_tracker.sv
// rtl/tl_cpl_rx_tracker.sv - receive-side completion tracker: tag lookup, DW accumulation, tag release
//
// Accepts decoded Cpl/CplD headers, resolves the tag against the tag table,
// accumulates received DWs per tag and frees the tag on the final or an
// erroneous completion. One done event is reported per processed completion.
//
// Optional feature macro: TL_CPL_REQID_CHECK_EN (compare completion requester
// ID against the tag table's requester ID; mismatch reports "unexpected").
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpl_valid_i / cpl_ready_o       completion header handshake
//   cpl_tag_i, cpl_status_i,
//   cpl_len_i, cpl_byte_cnt_i,
//   cpl_req_id_i                    completion header fields
//   lookup_tag_o, lookup_valid_o    tag table lookup request (one-cycle strobe)
//   lookup_ready_i, tbl_req_id_i,
//   tbl_len_i                       tag table response, one cycle after lookup
//   free_tag_o, free_valid_o        tag release strobe
//   done_valid_o, done_tag_o,
//   done_last_o, done_status_o      per-completion result (0 ok, 1 cpl error,
//                                   2 unexpected, 3 overflow)

module tl_cpl_rx_tracker #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 1 << TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpl_valid_i,
  output logic             cpl_ready_o,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [2:0]       cpl_status_i,
  input  logic [9:0]       cpl_len_i,
  input  logic [11:0]      cpl_byte_cnt_i,
  input  logic [15:0]      cpl_req_id_i,
  output logic [TAG_W-1:0] lookup_tag_o,
  output logic             lookup_valid_o,
  input  logic             lookup_ready_i,
  input  logic [15:0]      tbl_req_id_i,
  input  logic [9:0]       tbl_len_i,
  output logic [TAG_W-1:0] free_tag_o,
  output logic             free_valid_o,
  output logic             done_valid_o,
  output logic [TAG_W-1:0] done_tag_o,
  output logic             done_last_o,
  output logic [1:0]       done_status_o
);

  typedef enum logic [1:0] {IDLE, LOOK, RESP, DONE} state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_q;
  logic [2:0]       status_q;
  logic [9:0]       len_q;
  logic [11:0]      bc_q;
  logic [10:0]      acc [DEPTH];

  // Effective lengths: a zero field encodes the maximum (1024 DW / 4096 B).
  logic [12:0] len_eff, tbl_len_eff, bc_eff, acc_cur, acc_sum, len_bytes;

  logic [1:0]  res_status;
  logic        res_free;
  logic        res_acc_wr;
  logic [10:0] res_acc_val;

`ifdef TL_CPL_REQID_CHECK_EN
  logic [15:0] req_id_q;
`else
  logic unused_req_id;
  assign unused_req_id = ^{cpl_req_id_i, tbl_req_id_i};
`endif

  // acc never exceeds 1024 after a successful update, so the top sum bits
  // matter only for the overflow compare.
  logic unused_sum_hi;
  assign unused_sum_hi = ^acc_sum[12:11];

  assign len_eff     = {2'b00, (len_q == 10'd0), len_q};
  assign tbl_len_eff = {2'b00, (tbl_len_i == 10'd0), tbl_len_i};
  assign bc_eff      = {(bc_q == 12'd0), bc_q};
  assign acc_cur     = {2'b00, acc[tag_q]};
  assign acc_sum     = acc_cur + len_eff;
  assign len_bytes   = {len_eff[10:0], 2'b00};

  always_comb begin
    res_status  = 2'd0;
    res_free    = 1'b0;
    res_acc_wr  = 1'b0;
    res_acc_val = '0;
    if (!lookup_ready_i) begin
      res_status = 2'd2;
`ifdef TL_CPL_REQID_CHECK_EN
    end else if (req_id_q != tbl_req_id_i) begin
      res_status = 2'd2;
`endif
    end else if (status_q != 3'd0) begin
      res_status = 2'd1;
      res_free   = 1'b1;
      res_acc_wr = 1'b1;
    end else if (acc_sum > tbl_len_eff) begin
      res_status = 2'd3;
      res_free   = 1'b1;
      res_acc_wr = 1'b1;
    end else begin
      res_acc_wr = 1'b1;
      // Final completion: the remaining byte count fits in this payload.
      if (bc_eff <= len_bytes) begin
        res_free = 1'b1;
      end else begin
        res_acc_val = acc_sum[10:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cpl_valid_i) state_nxt = LOOK;
      LOOK: state_nxt = RESP;
      RESP: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpl_ready_o    = (state == IDLE);
  assign lookup_valid_o = (state == LOOK);
  assign lookup_tag_o   = (state == LOOK) ? tag_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tag_q         <= '0;
      status_q      <= '0;
      len_q         <= '0;
      bc_q          <= '0;
`ifdef TL_CPL_REQID_CHECK_EN
      req_id_q      <= '0;
`endif
      done_valid_o  <= 1'b0;
      done_tag_o    <= '0;
      done_last_o   <= 1'b0;
      done_status_o <= '0;
      free_valid_o  <= 1'b0;
      free_tag_o    <= '0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      state        <= state_nxt;
      done_valid_o <= (state == RESP);
      free_valid_o <= (state == RESP) && res_free;
      if (state == IDLE && cpl_valid_i) begin
        tag_q    <= cpl_tag_i;
        status_q <= cpl_status_i;
        len_q    <= cpl_len_i;
        bc_q     <= cpl_byte_cnt_i;
`ifdef TL_CPL_REQID_CHECK_EN
        req_id_q <= cpl_req_id_i;
`endif
      end
      if (state == RESP) begin
        done_tag_o    <= tag_q;
        done_status_o <= res_status;
        done_last_o   <= res_free;
        if (res_free) free_tag_o <= tag_q;
        if (res_acc_wr) acc[tag_q] <= res_acc_val;
      end
    end
  end

endmodule
